// File: rtl/song_transport_controller.sv
// Transport master for the APU note sequencers: frame-tick prescaler, tempo-driven
// note strobe, play/pause/stop control and song loop counting with auto-stop.
module song_transport_controller #(
    parameter int TICK_DIV      = 416667,
    parameter int DEFAULT_TEMPO = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_play,
    input  logic        i_pause,
    input  logic        i_stop,
    input  logic [4:0]  i_tempo,
    input  logic        i_tempo_load,
    input  logic [3:0]  i_loop_count,
    input  logic        i_song_end,
    output logic        o_seq_rst,
    output logic        o_tick_stb,
    output logic        o_note_stb,
    output logic [1:0]  o_state,
    output logic [15:0] o_step_count,
    output logic        o_done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [4:0]    TEMPO_RST = 5'(DEFAULT_TEMPO);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [4:0]    tickdown_reg, tickdown_next;
    logic [4:0]    tempo_reg, tempo_next;
    logic [15:0]   step_reg, step_next;
    logic [3:0]    loops_reg, loops_next;
    logic [3:0]    limit_reg, limit_next;
    logic          seq_rst_reg, seq_rst_next;
    logic          tick_reg, tick_next;
    logic          note_reg, note_next;
    logic          done_reg, done_next;
    logic          song_hit;
    logic          auto_stop;

    always_comb begin
        state_next    = state_reg;
        presc_next    = presc_reg;
        tickdown_next = tickdown_reg;
        tempo_next    = tempo_reg;
        step_next     = step_reg;
        loops_next    = loops_reg;
        limit_next    = limit_reg;
        tick_next     = 1'b0;
        note_next     = 1'b0;
        done_next     = 1'b0;
        song_hit      = 1'b0;
        auto_stop     = 1'b0;

        // A load takes effect at the next reload; a reload this cycle still uses tempo_reg.
        if (i_tempo_load) begin
            tempo_next = (i_tempo == 5'd0) ? 5'd1 : i_tempo;
        end

        case (state_reg)
            IDLE: begin
                if (!i_stop && i_play) begin
                    state_next = PRIME;
                    limit_next = i_loop_count;
                end
            end
            PRIME: begin
                if (i_stop) begin
                    state_next = IDLE;
                end else begin
                    presc_next    = '0;
                    tickdown_next = 5'd0;
                    step_next     = 16'd0;
                    loops_next    = 4'd0;
                    state_next    = PLAY;
                end
            end
            PLAY: begin
                song_hit = i_song_end && !i_stop;
                if (song_hit) begin
                    if (loops_reg != 4'hF) begin
                        loops_next = loops_reg + 4'd1;
                    end
                    // A saturated count wraps to 0 here, which the nonzero limit excludes.
                    auto_stop = (limit_reg != 4'd0) && ((loops_reg + 4'd1) == limit_reg);
                end
                if (i_stop || auto_stop) begin
                    state_next = IDLE;
                    done_next  = auto_stop;
                end else if (i_pause) begin
                    state_next = PAUSE;
                end else if (presc_reg == PRESC_MAX) begin
                    presc_next = '0;
                    tick_next  = 1'b1;
                    if (tickdown_reg == 5'd0) begin
                        note_next     = 1'b1;
                        step_next     = step_reg + 16'd1;
                        tickdown_next = tempo_reg - 5'd1;
                    end else begin
                        tickdown_next = tickdown_reg - 5'd1;
                    end
                end else begin
                    presc_next = presc_reg + PW'(1);
                end
            end
            PAUSE: begin
                if (i_stop) begin
                    state_next = IDLE;
                end else if (i_play) begin
                    state_next = PLAY;
                end
            end
            default: state_next = IDLE;
        endcase

        seq_rst_next = (state_next == IDLE) || (state_next == PRIME);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            presc_reg    <= '0;
            tickdown_reg <= 5'd0;
            tempo_reg    <= TEMPO_RST;
            step_reg     <= 16'd0;
            loops_reg    <= 4'd0;
            limit_reg    <= 4'd0;
            seq_rst_reg  <= 1'b1;
            tick_reg     <= 1'b0;
            note_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            presc_reg    <= presc_next;
            tickdown_reg <= tickdown_next;
            tempo_reg    <= tempo_next;
            step_reg     <= step_next;
            loops_reg    <= loops_next;
            limit_reg    <= limit_next;
            seq_rst_reg  <= seq_rst_next;
            tick_reg     <= tick_next;
            note_reg     <= note_next;
            done_reg     <= done_next;
        end
    end

    assign o_seq_rst    = seq_rst_reg;
    assign o_tick_stb   = tick_reg;
    assign o_note_stb   = note_reg;
    assign o_state      = state_reg;
    assign o_step_count = step_reg;
    assign o_done       = done_reg;

endmodule

// File: tb/tb_song_transport_controller.sv
// Bench for song_transport_controller: directed scenarios then random commands,
// all checked cycle by cycle against a tick/note schedule model.
module tb_song_transport_controller;

    localparam int TD  = 4;
    localparam int DEF = 6;
    localparam int M_IDLE = 0, M_PRIME = 1, M_PLAY = 2, M_PAUSE = 3;

    logic        clk = 1'b0;
    logic        rst, play, pause, stop, tempo_load, song_end;
    logic [4:0]  tempo;
    logic [3:0]  loop_count;
    logic        seq_rst, tick_stb, note_stb, done;
    logic [1:0]  state;
    logic [15:0] step_count;

    int checks = 0;
    int errors = 0;

    // Model: time is counted in playing cycles; ticks and notes are scheduled events.
    int m_mode, m_elapsed, m_ticks, m_next_note, m_notes, m_loops, m_limit, m_tempo;
    logic exp_tick, exp_note, exp_done;
    int obs_ticks, obs_notes, obs_dones;

    song_transport_controller #(.TICK_DIV(TD), .DEFAULT_TEMPO(DEF)) dut (
        .i_clk(clk), .i_rst(rst), .i_play(play), .i_pause(pause), .i_stop(stop),
        .i_tempo(tempo), .i_tempo_load(tempo_load), .i_loop_count(loop_count),
        .i_song_end(song_end), .o_seq_rst(seq_rst), .o_tick_stb(tick_stb),
        .o_note_stb(note_stb), .o_state(state), .o_step_count(step_count), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int  tempo_after;
        bit  autostop;
        exp_tick = 1'b0;
        exp_note = 1'b0;
        exp_done = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_elapsed = 0; m_ticks = 0; m_next_note = 1;
            m_notes = 0; m_loops = 0; m_limit = 0; m_tempo = DEF;
        end else begin
            tempo_after = m_tempo;
            autostop = 1'b0;
            if (tempo_load) tempo_after = (tempo == 5'd0) ? 1 : int'(tempo);
            if (m_mode == M_IDLE) begin
                if (!stop && play) begin m_mode = M_PRIME; m_limit = int'(loop_count); end
            end else if (m_mode == M_PRIME) begin
                if (stop) m_mode = M_IDLE;
                else begin
                    m_elapsed = 0; m_ticks = 0; m_next_note = 1; m_notes = 0; m_loops = 0;
                    m_mode = M_PLAY;
                end
            end else if (m_mode == M_PLAY) begin
                if (song_end && !stop) begin
                    if (m_limit != 0 && m_loops + 1 == m_limit) autostop = 1'b1;
                    if (m_loops < 15) m_loops++;
                end
                if (stop || autostop) begin
                    m_mode = M_IDLE;
                    exp_done = autostop;
                end else if (pause) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_elapsed++;
                    if (m_elapsed % TD == 0) begin
                        exp_tick = 1'b1;
                        m_ticks++;
                        if (m_ticks == m_next_note) begin
                            exp_note = 1'b1;
                            m_notes++;
                            m_next_note = m_ticks + m_tempo;
                        end
                    end
                end
            end else begin
                if (stop) m_mode = M_IDLE;
                else if (play) m_mode = M_PLAY;
            end
            m_tempo = tempo_after;
        end
    endtask

    // One clock: model consumes current inputs, DUT outputs compared 1 time unit after the edge.
    task automatic cyc();
        model_update();
        @(posedge clk);
        #1;
        check("state",   {14'd0, state}, 16'(m_mode));
        check("seq_rst", {15'd0, seq_rst}, {15'd0, (m_mode == M_IDLE || m_mode == M_PRIME)});
        check("tick",    {15'd0, tick_stb}, {15'd0, exp_tick});
        check("note",    {15'd0, note_stb}, {15'd0, exp_note});
        check("step",    step_count, 16'(m_notes));
        check("done",    {15'd0, done}, {15'd0, exp_done});
        obs_ticks += int'(tick_stb);
        obs_notes += int'(note_stb);
        obs_dones += int'(done);
        play = 0; pause = 0; stop = 0; tempo_load = 0; song_end = 0; rst = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clear_obs();
        obs_ticks = 0; obs_notes = 0; obs_dones = 0;
    endtask

    initial begin
        rst = 1; play = 0; pause = 0; stop = 0; tempo_load = 0; song_end = 0;
        tempo = 5'd0; loop_count = 4'd0;
        clear_obs();

        // 1: reset, tempo 3, play; notes on ticks 1,4,7
        rst = 1; cyc(); rst = 1; cyc();
        check("rst_state", {14'd0, state}, 16'd0);
        check("rst_seq_rst", {15'd0, seq_rst}, 16'd1);
        tempo = 5'd3; tempo_load = 1; cyc();
        play = 1; cyc();
        check("prime_state", {14'd0, state}, 16'd1);
        check("prime_seq_rst", {15'd0, seq_rst}, 16'd1);
        cyc();
        clear_obs();
        run(4 * 7);
        check("t1_ticks", 16'(obs_ticks), 16'd7);
        check("t1_notes", 16'(obs_notes), 16'd3);
        check("t1_step", step_count, 16'd3);
        $display("transaction: play tempo 3, ticks=%0d notes=%0d step=%0d", obs_ticks, obs_notes, step_count);

        // 2: pause, hold 20 cycles, resume
        pause = 1; cyc();
        clear_obs();
        run(20);
        check("pause_ticks", 16'(obs_ticks), 16'd0);
        check("pause_step", step_count, 16'd3);
        play = 1; cyc();
        run(4 * 6);
        $display("transaction: pause/resume, step=%0d", step_count);

        // 3: loop_count 2 -> auto-stop on 2nd song_end; then loop forever
        stop = 1; cyc();
        loop_count = 4'd2; play = 1; cyc();
        run(11);
        song_end = 1; cyc();
        run(6);
        song_end = 1; cyc();
        check("auto_done", {15'd0, done}, 16'd1);
        check("auto_state", {14'd0, state}, 16'd0);
        cyc();
        check("auto_done_once", {15'd0, done}, 16'd0);
        loop_count = 4'd0; play = 1; cyc();
        clear_obs();
        for (int k = 0; k < 5; k++) begin
            run(3);
            song_end = 1; cyc();
        end
        check("forever_dones", 16'(obs_dones), 16'd0);
        check("forever_state", {14'd0, state}, 16'd2);
        $display("transaction: loop counting, state=%0d", state);

        // 4: tempo 0 (one tick per note), then 5 loaded mid-note
        tempo = 5'd0; tempo_load = 1; cyc();
        run(40);
        run(2);
        tempo = 5'd5; tempo_load = 1; cyc();
        run(80);
        $display("transaction: tempo changes, step=%0d", step_count);

        // 5: stop in the rollover cycle; stop+play; song_end+stop
        for (int k = 0; k < 8 && (m_elapsed % TD) != TD - 1; k++) cyc();
        check("roll_phase", 16'(m_elapsed % TD), 16'(TD - 1));
        stop = 1; cyc();
        check("roll_tick", {15'd0, tick_stb}, 16'd0);
        check("roll_state", {14'd0, state}, 16'd0);
        stop = 1; play = 1; cyc();
        check("stop_play_state", {14'd0, state}, 16'd0);
        loop_count = 4'd1; play = 1; cyc();
        run(9);
        song_end = 1; stop = 1; cyc();
        check("end_stop_done", {15'd0, done}, 16'd0);
        $display("transaction: stop corner cases, state=%0d", state);

        // 6: reset during PLAY and PAUSE; default tempo afterwards
        loop_count = 4'd0; play = 1; cyc();
        run(13);
        rst = 1; cyc();
        check("rst_play_state", {14'd0, state}, 16'd0);
        check("rst_play_step", step_count, 16'd0);
        play = 1; cyc();
        run(30);
        pause = 1; cyc();
        run(3);
        rst = 1; cyc();
        check("rst_pause_seq_rst", {15'd0, seq_rst}, 16'd1);
        play = 1; cyc();
        clear_obs();
        run(4 * 13 + 1);
        check("default_tempo_notes", 16'(obs_notes), 16'd3);
        $display("transaction: reset recovery, notes=%0d", obs_notes);

        // Random commands against the model
        for (int i = 0; i < 3000; i++) begin
            play       = ($urandom_range(0, 19) == 0);
            pause      = ($urandom_range(0, 29) == 0);
            stop       = ($urandom_range(0, 59) == 0);
            tempo_load = ($urandom_range(0, 39) == 0);
            tempo      = 5'($urandom_range(0, 7));
            loop_count = 4'($urandom_range(0, 3));
            song_end   = ($urandom_range(0, 24) == 0);
            rst        = ($urandom_range(0, 499) == 0);
            cyc();
        end
        $display("transaction: random run done, step=%0d", step_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
